// File: rtl/fifo_pack32.sv
// Packs FIFO bytes into 32-bit words (big-endian, or little-endian with FIFO_PACK32_LE_EN); OUT_VALID 2 cycles after the 4th byte lands.
// Backpressure: holds 4 bytes in assembly plus 1 output word, REN drops until space frees; FLUSH emits a padded partial word.
module fifo_pack32 #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EMPTY,
    output logic        REN,
    input  logic [7:0]  RDAT,
    input  logic        RDAT_EN,
    input  logic        FLUSH,
    output logic        FLUSH_DONE,
    output logic [31:0] OUT_DATA,
    output logic [2:0]  OUT_BYTES,
    output logic        OUT_VALID,
    input  logic        OUT_READY
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FL_WAIT,
        ST_FL_EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0][7:0]  lane_q, lane_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [2:0]       out_bytes_q, out_bytes_d;
    logic             out_valid_q, out_valid_d;

    logic             xfer;
    logic [2:0]       base;
    logic [31:0]      packed_word;
    logic [7:0]       lane_byte;

    always_comb begin
        xfer = (!out_valid_q || OUT_READY) &&
               ((cnt_q == 3'd4) || ((state_q == ST_FL_EMIT) && (cnt_q != 3'd0)));
        base = xfer ? 3'd0 : cnt_q;
        // Count the byte already in flight so a new pop always has a free lane.
        REN  = !RESET && !EMPTY && (state_q == ST_RUN) &&
               (({1'b0, base} + {3'b000, RDAT_EN}) < 4'd4);
    end

    always_comb begin
        packed_word = '0;
        lane_byte   = '0;
        for (int i = 0; i < 4; i++) begin
            lane_byte = (3'(i) < cnt_q) ? lane_q[i] : PAD_BYTE;
`ifdef FIFO_PACK32_LE_EN
            packed_word[8*i +: 8] = lane_byte;
`else
            packed_word[8*(3-i) +: 8] = lane_byte;
`endif
        end
    end

    always_comb begin
        lane_d = lane_q;
        cnt_d  = base;
        if (RDAT_EN) begin
            lane_d[base[1:0]] = RDAT;
            cnt_d             = base + 3'd1;
        end

        out_valid_d = xfer || (out_valid_q && !OUT_READY);
        out_data_d  = xfer ? packed_word : out_data_q;
        out_bytes_d = xfer ? cnt_q : out_bytes_q;
    end

    always_comb begin
        state_d    = state_q;
        FLUSH_DONE = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (FLUSH) state_d = ST_FL_WAIT;
            end
            ST_FL_WAIT: begin
                state_d = ST_FL_EMIT;
            end
            ST_FL_EMIT: begin
                if ((cnt_q == 3'd0) || xfer) begin
                    FLUSH_DONE = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            lane_q      <= '0;
            cnt_q       <= 3'd0;
            out_data_q  <= '0;
            out_bytes_q <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_BYTES = out_bytes_q;
    assign OUT_VALID = out_valid_q;

endmodule
